// File: rtl/quark_issue_seq.sv
// Instruction issue sequencer: holds one 64-bit word with its slot offsets and
// issues one decoded opcode plus sign-extended immediate tail per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no word held; upstream may load unconditionally
// S_ISSUE | word held; instruction idx_q presented on op_*
module quark_issue_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        ir_valid,
    output logic        ir_ready,
    input  logic [63:0] ir,
    input  logic [63:0] toff,
    input  logic [4:0]  icnt,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [3:0]  op,
    output logic [31:0] imm,
    output logic [2:0]  imm_len,
    output logic [3:0]  op_slot,
    output logic        op_last,
    output logic        op_err
);

    typedef enum logic {S_EMPTY, S_ISSUE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [63:0] ir_q, ir_d;
    logic [63:0] toff_q, toff_d;
    logic [4:0]  icnt_q, icnt_d;
    logic        cnt_err_q, cnt_err_d;

    logic [3:0]  dec_slot;
    logic [3:0]  dec_op;
    logic [3:0]  idx_p1;
    logic [3:0]  nxt_field;
    logic [4:0]  next5;
    logic [4:0]  raw5;
    logic        dec_last;
    logic [2:0]  dec_len;
    logic        dec_err;
    logic [4:0]  tslot;
    logic [27:0] tail;
    logic [3:0]  inv_len;
    logic [31:0] dec_imm;
    logic        valid_int;
    logic        fire;
    logic        load;

    // Decode is purely from the held word and index, so op_* never see op_ready.
    always_comb begin
        dec_slot  = toff_q[{idx_q, 2'b00} +: 4];
        dec_op    = ir_q[{~dec_slot, 2'b00} +: 4];
        idx_p1    = idx_q + 4'd1;
        nxt_field = toff_q[{idx_p1, 2'b00} +: 4];
        dec_last  = ({1'b0, idx_q} == (icnt_q - 5'd1));
        next5     = dec_last ? 5'd16 : {1'b0, nxt_field};
        raw5      = next5 - {1'b0, dec_slot} - 5'd1;
        dec_len   = 3'd0;
        dec_err   = cnt_err_q;
        if (next5 <= {1'b0, dec_slot}) begin
            dec_err = 1'b1;
        end else if (raw5 > 5'd7) begin
            dec_len = 3'd7;
            dec_err = 1'b1;
        end else begin
            dec_len = raw5[2:0];
        end

        // Gather up to seven nibbles after the opcode, first one in the MSB.
        tail  = 28'd0;
        tslot = 5'd0;
        for (int i = 0; i < 7; i++) begin
            tslot = {1'b0, dec_slot} + 5'(i + 1);
            if (tslot < 5'd16) begin
                tail[27-4*i -: 4] = ir_q[{~tslot[3:0], 2'b00} +: 4];
            end
        end

        inv_len = 4'd8 - {1'b0, dec_len};
        if (dec_len == 3'd0) begin
            dec_imm = 32'd0;
        end else begin
            dec_imm = $signed({tail, 4'h0}) >>> {inv_len, 2'b00};
        end
    end

    always_comb begin
        valid_int = reset_n && (state_q == S_ISSUE);
        fire      = valid_int && op_ready;
        ir_ready  = reset_n && !flush && ((state_q == S_EMPTY) || (fire && dec_last));
        load      = ir_valid && ir_ready;

        op_valid  = valid_int;
        op        = valid_int ? dec_op   : 4'd0;
        imm       = valid_int ? dec_imm  : 32'd0;
        imm_len   = valid_int ? dec_len  : 3'd0;
        op_slot   = valid_int ? dec_slot : 4'd0;
        op_last   = valid_int && dec_last;
        op_err    = valid_int && dec_err;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ir_d      = ir_q;
        toff_d    = toff_q;
        icnt_d    = icnt_q;
        cnt_err_d = cnt_err_q;
        if (flush) begin
            state_d = S_EMPTY;
            idx_d   = 4'd0;
        end else if (load) begin
            state_d   = S_ISSUE;
            idx_d     = 4'd0;
            ir_d      = ir;
            toff_d    = toff;
            // A zero count still issues one (flagged) instruction; counts above 16 saturate.
            icnt_d    = (icnt == 5'd0) ? 5'd1 : ((icnt > 5'd16) ? 5'd16 : icnt);
            cnt_err_d = (icnt == 5'd0);
        end else if (fire) begin
            if (dec_last) begin
                state_d = S_EMPTY;
                idx_d   = 4'd0;
            end else begin
                idx_d = idx_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_EMPTY;
            idx_q     <= 4'd0;
            ir_q      <= 64'd0;
            toff_q    <= 64'd0;
            icnt_q    <= 5'd1;
            cnt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ir_q      <= ir_d;
            toff_q    <= toff_d;
            icnt_q    <= icnt_d;
            cnt_err_q <= cnt_err_d;
        end
    end

endmodule

// File: tb/tb_quark_issue_seq.sv
// Scoreboard bench for quark_issue_seq: stimulus pushes expected ops, a negedge
// monitor pops and compares on every accepted op and checks stall stability.
module tb_quark_issue_seq;

    logic        clk = 1'b0;
    logic        reset_n, flush, ir_valid, op_ready;
    logic [63:0] ir, toff;
    logic [4:0]  icnt;
    logic        ir_ready, op_valid, op_last, op_err;
    logic [3:0]  op, op_slot;
    logic [31:0] imm;
    logic [2:0]  imm_len;

    always #5 clk = ~clk;

    quark_issue_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .ir       (ir),
        .toff     (toff),
        .icnt     (icnt),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .imm      (imm),
        .imm_len  (imm_len),
        .op_slot  (op_slot),
        .op_last  (op_last),
        .op_err   (op_err)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] imm;
        logic [2:0]  len;
        logic [3:0]  slot;
        logic        last;
        logic        err;
    } exp_t;

    localparam logic [63:0] W_ZERO_IR   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W_ZERO_TOFF = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W_MIX_IR    = 64'h5F89_3123_4570_0001;
    localparam logic [63:0] W_MIX_TOFF  = 64'h0000_0000_0000_A430;
    localparam logic [63:0] W_B_IR      = 64'hA123_4567_89BC_DEF0;
    localparam logic [63:0] W_B_TOFF    = 64'h0000_0000_0000_0090;
    localparam logic [63:0] W_C_IR      = 64'h8F00_0000_0000_0000;
    localparam logic [63:0] W_D_IR      = 64'h3712_3456_7000_0000;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic exp_t mk(logic [3:0] o, logic [31:0] i, logic [2:0] l,
                                logic [3:0] s, logic la, logic e);
        mk = {o, i, l, s, la, e};
    endfunction

    task automatic push_zero();
        for (int k = 0; k < 16; k++) sb.push_back(mk(4'(k), 32'd0, 3'd0, 4'(k), k == 15, 1'b0));
    endtask

    task automatic push_mix(int n);
        exp_t m[4];
        m[0] = mk(4'h5, 32'hFFFF_FFF8, 3'd2, 4'd0,  1'b0, 1'b0);
        m[1] = mk(4'h9, 32'h0000_0000, 3'd0, 4'd3,  1'b0, 1'b0);
        m[2] = mk(4'h3, 32'h0001_2345, 3'd5, 4'd4,  1'b0, 1'b0);
        m[3] = mk(4'h7, 32'h0000_0001, 3'd5, 4'd10, 1'b1, 1'b0);
        for (int k = 0; k < n; k++) sb.push_back(m[k]);
    endtask

    task automatic push_b();
        sb.push_back(mk(4'hA, 32'h0123_4567, 3'd7, 4'd0, 1'b0, 1'b1));
        sb.push_back(mk(4'h9, 32'hFFBC_DEF0, 3'd6, 4'd9, 1'b1, 1'b0));
    endtask

    exp_t mon_cur, mon_prev, mon_e;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        mon_cur = {op, imm, imm_len, op_slot, op_last, op_err};
        if (prev_stall) check("stall_hold", 64'(mon_cur), 64'(mon_prev));
        if (reset_n && op_valid && op_ready && !flush) begin
            if (sb.size() == 0) begin
                check("unexpected_op", 64'(mon_cur), 64'h0);
            end else begin
                mon_e = sb.pop_front();
                check("op_fields", 64'(mon_cur), 64'(mon_e));
            end
        end
        prev_stall = reset_n && op_valid && !op_ready && !flush;
        mon_prev   = mon_cur;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [63:0] w_ir, logic [63:0] w_toff, logic [4:0] w_icnt);
        bit got = 1'b0;
        ir = w_ir; toff = w_toff; icnt = w_icnt; ir_valid = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (ir_ready) got = 1'b1;
            step();
        end
        ir_valid = 1'b0;
        if (!got) check("load_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        op_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        step();
        @(negedge clk);
        check("idle_op_valid", 64'(op_valid), 64'd0);
        step();
    endtask

    int acc;

    initial begin
        reset_n = 1'b0; flush = 1'b0; op_ready = 1'b1;
        ir_valid = 1'b1; ir = W_MIX_IR; toff = W_MIX_TOFF; icnt = 5'd4;

        repeat (3) begin
            @(negedge clk);
            check("rst_op_valid", 64'(op_valid), 64'd0);
            check("rst_ir_ready", 64'(ir_ready), 64'd0);
        end
        step();
        reset_n = 1'b1; ir_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ir_ready", 64'(ir_ready), 64'd1);
        check("post_rst_op_valid", 64'(op_valid), 64'd0);
        step();

        push_zero();
        load(W_ZERO_IR, W_ZERO_TOFF, 5'd16);
        drain();

        push_mix(4);
        load(W_MIX_IR, W_MIX_TOFF, 5'd4);
        drain();

        // Back-pressure 1,0,0,... with word B queued behind the mixed word.
        push_mix(4);
        push_b();
        load(W_MIX_IR, W_MIX_TOFF, 5'd4);
        ir = W_B_IR; toff = W_B_TOFF; icnt = 5'd2; ir_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 40 && acc < 6; c++) begin
            op_ready = (c % 3 == 0);
            @(negedge clk);
            check("bp_op_valid", 64'(op_valid), 64'd1);
            check("bp_ir_ready", 64'(ir_ready), 64'(op_ready && (acc == 3 || acc == 5)));
            if (op_ready) acc++;
            step();
            if (acc >= 4) ir_valid = 1'b0;
        end
        check("bp_accepts", 64'(acc), 64'd6);
        drain();

        // Flush on the second instruction with a new word offered.
        push_mix(1);
        load(W_MIX_IR, W_MIX_TOFF, 5'd4);
        @(negedge clk);
        step();
        flush = 1'b1; ir = W_B_IR; toff = W_B_TOFF; icnt = 5'd2; ir_valid = 1'b1;
        @(negedge clk);
        check("flush_ir_ready", 64'(ir_ready), 64'd0);
        check("flush_op_slot", 64'(op_slot), 64'd3);
        step();
        flush = 1'b0;
        push_b();
        @(negedge clk);
        check("post_flush_op_valid", 64'(op_valid), 64'd0);
        check("post_flush_ir_ready", 64'(ir_ready), 64'd1);
        step();
        ir_valid = 1'b0;
        @(negedge clk);
        check("reload_op_valid", 64'(op_valid), 64'd1);
        drain();

        sb.push_back(mk(4'h8, 32'h0000_0000, 3'd0, 4'd0, 1'b0, 1'b1));
        sb.push_back(mk(4'h8, 32'hFF00_0000, 3'd7, 4'd0, 1'b1, 1'b1));
        load(W_C_IR, 64'd0, 5'd2);
        drain();

        sb.push_back(mk(4'h3, 32'h0712_3456, 3'd7, 4'd0, 1'b1, 1'b1));
        load(W_D_IR, 64'd0, 5'd0);
        drain();

        // Reset mid-word drops the rest of the word.
        push_mix(4);
        load(W_MIX_IR, W_MIX_TOFF, 5'd4);
        @(negedge clk);
        step();
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_op_valid", 64'(op_valid), 64'd0);
        check("midrst_ir_ready", 64'(ir_ready), 64'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("after_midrst_op_valid", 64'(op_valid), 64'd0);
        check("after_midrst_ir_ready", 64'(ir_ready), 64'd1);
        step();

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
